// File: rtl/spatz_xmem_pkg.sv
// rtl/spatz_xmem_pkg.sv - shared types and helpers for the x_mem responder
package spatz_xmem_pkg;

  localparam int unsigned XMEM_ID_WIDTH   = 4;
  localparam int unsigned XMEM_PORT_WIDTH = 4;

  localparam logic [5:0] EXC_LD_MISALIGNED = 6'd4;
  localparam logic [5:0] EXC_ST_MISALIGNED = 6'd6;

  typedef struct packed {
    logic [XMEM_ID_WIDTH-1:0] id;
    logic [31:0]              addr;
    logic                     we;
    logic [1:0]               size;
    logic [31:0]              wdata;
  } xmem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } xmem_resp_t;

  typedef struct packed {
    logic [XMEM_ID_WIDTH-1:0] id;
    logic [31:0]              rdata;
    logic                     err;
  } xmem_result_t;

  // One entry per granted memory access, kept in issue order.
  typedef struct packed {
    logic [XMEM_PORT_WIDTH-1:0] port;
    logic [XMEM_ID_WIDTH-1:0]   id;
    logic                       we;
    logic [1:0]                 size;
    logic [1:0]                 offset;
  } xmem_tracker_t;

  // size=3 has no legal encoding and is treated like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      2'd2:    return (offset != 2'd0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small synchronous FIFO with optional fall-through
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic [31:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  dtype          mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          is_empty, bypass, do_push, do_pop;

  // Status flags and read data, with the optional empty-bypass path.
  always_comb begin
    is_empty = (count_q == '0);
    full_o   = (count_q == CW'(DEPTH));
    bypass   = FALL_THROUGH && is_empty && push_i;
    empty_o  = is_empty && !bypass;
    data_o   = bypass ? data_i : mem_q[rd_ptr_q];
    do_push  = push_i && !full_o && !(bypass && pop_i);
    do_pop   = pop_i && !is_empty;
  end

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/spatz_xmem_rr_arb.sv
// rtl/spatz_xmem_rr_arb.sv - round-robin arbiter with accept-driven pointer
module spatz_xmem_rr_arb #(
  parameter int unsigned N    = 2,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    valid_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [IDXW-1:0] ptr_q;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_o = '0;
    idx_o = ptr_q;
    any_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = (int'(ptr_q) + i) % int'(N);
      if (!any_o && valid_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDXW'(j);
      end
    end
  end

  // The pointer moves past the winner only when its request is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && any_o) begin
      ptr_q <= (idx_o == IDXW'(N - 1)) ? '0 : idx_o + IDXW'(1);
    end
  end

endmodule

// File: rtl/spatz_xmem_responder.sv
// rtl/spatz_xmem_responder.sv - x_mem request arbitration onto one word memory port
module spatz_xmem_responder
  import spatz_xmem_pkg::*;
#(
  parameter int unsigned NR_MEM_PORTS   = 2,
  parameter int unsigned NR_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH       = XMEM_ID_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic         [NR_MEM_PORTS-1:0] x_mem_valid_i,
  output logic         [NR_MEM_PORTS-1:0] x_mem_ready_o,
  input  xmem_req_t    [NR_MEM_PORTS-1:0] x_mem_req_i,
  output xmem_resp_t   [NR_MEM_PORTS-1:0] x_mem_resp_o,
  output logic         [NR_MEM_PORTS-1:0] x_mem_result_valid_o,
  output xmem_result_t [NR_MEM_PORTS-1:0] x_mem_result_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic         [31:0]             mem_addr_o,
  output logic                            mem_we_o,
  output logic         [3:0]              mem_be_o,
  output logic         [31:0]             mem_wdata_o,
  input  logic                            mem_rvalid_i,
  input  logic         [31:0]             mem_rdata_i,
  input  logic                            mem_err_i
);

  localparam int unsigned IdxW = (NR_MEM_PORTS > 1) ? $clog2(NR_MEM_PORTS) : 1;

  logic [NR_MEM_PORTS-1:0] arb_valid, arb_gnt;
  logic [IdxW-1:0]         win_idx;
  logic                    win_any, win_bad, accept, push, pop, full, empty;
  xmem_req_t               win_req;
  xmem_tracker_t           push_entry, head;
  logic [ID_WIDTH-1:0]     head_id;
  logic [31:0]             rdata_shift, rdata_ext;

  // Requests are masked during reset so every output is quiet while rst_i is high.
  assign arb_valid = x_mem_valid_i & {NR_MEM_PORTS{~rst_i}};

  spatz_xmem_rr_arb #(
    .N    (NR_MEM_PORTS),
    .IDXW (IdxW)
  ) i_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (arb_valid),
    .advance_i (accept),
    .gnt_o     (arb_gnt),
    .idx_o     (win_idx),
    .any_o     (win_any)
  );

  // Request side: misaligned requests bypass memory and tracker entirely.
  always_comb begin
    win_req    = x_mem_req_i[win_idx];
    win_bad    = win_any && is_misaligned(win_req.size, win_req.addr[1:0]);
    mem_req_o  = win_any && !win_bad && !full;
    push       = mem_req_o && mem_gnt_i;
    accept     = win_bad || push;

    x_mem_ready_o = accept ? arb_gnt : '0;
    for (int p = 0; p < int'(NR_MEM_PORTS); p++) begin
      x_mem_resp_o[p] = '0;
      if (win_bad && arb_gnt[p]) begin
        x_mem_resp_o[p].exc     = 1'b1;
        x_mem_resp_o[p].exccode = win_req.we ? EXC_ST_MISALIGNED : EXC_LD_MISALIGNED;
      end
    end

    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o  = {win_req.addr[31:2], 2'b00};
      mem_we_o    = win_req.we;
      mem_be_o    = byte_enable(win_req.size, win_req.addr[1:0]);
      mem_wdata_o = win_req.wdata << {win_req.addr[1:0], 3'b000};
    end

    push_entry.port   = XMEM_PORT_WIDTH'(win_idx);
    push_entry.id     = win_req.id;
    push_entry.we     = win_req.we;
    push_entry.size   = win_req.size;
    push_entry.offset = win_req.addr[1:0];
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (NR_OUTSTANDING),
    .dtype        (xmem_tracker_t)
  ) i_tracker (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (push_entry),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  // Response side: load data is realigned and returned in the rvalid cycle.
  always_comb begin
    pop         = mem_rvalid_i && !empty && !rst_i;
    head_id     = head.id;
    rdata_shift = mem_rdata_i >> {head.offset, 3'b000};
    case (head.size)
      2'd0:    rdata_ext = {24'h0, rdata_shift[7:0]};
      2'd1:    rdata_ext = {16'h0, rdata_shift[15:0]};
      default: rdata_ext = rdata_shift;
    endcase
    for (int p = 0; p < int'(NR_MEM_PORTS); p++) begin
      x_mem_result_valid_o[p] = pop && !head.we && (head.port == XMEM_PORT_WIDTH'(p));
      x_mem_result_o[p]       = '0;
      if (x_mem_result_valid_o[p]) begin
        x_mem_result_o[p].id    = head_id;
        x_mem_result_o[p].rdata = rdata_ext;
        x_mem_result_o[p].err   = mem_err_i;
      end
    end
  end

  // A memory response with nothing outstanding means the backing store broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && empty));

endmodule

// File: tb/tb_spatz_xmem_responder.sv
// tb/tb_spatz_xmem_responder.sv - directed self-checking bench for spatz_xmem_responder
module tb_spatz_xmem_responder;
  import spatz_xmem_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic         [1:0] valid;
  logic         [1:0] ready;
  xmem_req_t    [1:0] req;
  xmem_resp_t   [1:0] resp;
  logic         [1:0] res_valid;
  xmem_result_t [1:0] res;
  logic               mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic        [31:0] mem_addr, mem_wdata, mem_rdata;
  logic         [3:0] mem_be;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  spatz_xmem_responder #(
    .NR_MEM_PORTS   (2),
    .NR_OUTSTANDING (4),
    .ID_WIDTH       (4)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .x_mem_valid_i        (valid),
    .x_mem_ready_o        (ready),
    .x_mem_req_i          (req),
    .x_mem_resp_o         (resp),
    .x_mem_result_valid_o (res_valid),
    .x_mem_result_o       (res),
    .mem_req_o            (mem_req),
    .mem_gnt_i            (mem_gnt),
    .mem_addr_o           (mem_addr),
    .mem_we_o             (mem_we),
    .mem_be_o             (mem_be),
    .mem_wdata_o          (mem_wdata),
    .mem_rvalid_i         (mem_rvalid),
    .mem_rdata_i          (mem_rdata),
    .mem_err_i            (mem_err)
  );

  function automatic xmem_req_t mk(input logic [3:0] id, input logic [31:0] addr,
                                   input logic we, input logic [1:0] size, input logic [31:0] wdata);
    xmem_req_t r;
    r.id = id; r.addr = addr; r.we = we; r.size = size; r.wdata = wdata;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0; req = '0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    valid[0] = 1'b1;
    req[0] = mk(4'd1, 32'h100, 1'b0, 2'd2, 32'h0);
    mem_gnt = 1'b1;
    #1;
    total++;
    if ({mem_req, ready, res_valid, mem_be} !== 9'h0)
      $display("FAIL reset_outputs: got req=%b ready=%b rv=%b be=%h, want all 0", mem_req, ready, res_valid, mem_be);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_load();
    tick();
    valid[0] = 1'b1;
    req[0] = mk(4'd3, 32'h104, 1'b0, 2'd2, 32'h0);
    mem_gnt = 1'b1;
    #1;
    total++;
    if ({mem_req, mem_addr, mem_be, ready} !== {1'b1, 32'h104, 4'hF, 2'b01})
      $display("FAIL single_req: got req=%b addr=%h be=%h ready=%b, want 1 104 f 01", mem_req, mem_addr, mem_be, ready);
    else pass_cnt++;
    tick();
    idle();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if ({res_valid, res[0].id, res[0].rdata, res[0].err} !== {2'b01, 4'd3, 32'hDEADBEEF, 1'b0})
      $display("FAIL single_result: got rv=%b id=%0d rdata=%h err=%b, want 01 3 deadbeef 0",
               res_valid, res[0].id, res[0].rdata, res[0].err);
    else pass_cnt++;
    tick();
    idle();
    total++;
    if (res_valid !== 2'b00) $display("FAIL single_strobe: got rv=%b, want 00", res_valid);
    else pass_cnt++;
  endtask

  task automatic test_subword();
    tick();
    valid[0] = 1'b1;
    req[0] = mk(4'd4, 32'h107, 1'b0, 2'd0, 32'h0);
    mem_gnt = 1'b1;
    #1;
    total++;
    if ({mem_be, mem_addr, ready} !== {4'h8, 32'h104, 2'b01})
      $display("FAIL byte_req: got be=%h addr=%h ready=%b, want 8 104 01", mem_be, mem_addr, ready);
    else pass_cnt++;
    tick();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'hAABBCCDD;
    #1;
    total++;
    if ({res_valid, res[0].rdata} !== {2'b01, 32'h000000AA})
      $display("FAIL byte_result: got rv=%b rdata=%h, want 01 000000aa", res_valid, res[0].rdata);
    else pass_cnt++;
    tick();
    idle();
    // Halfword store on port 1 leaves the round-robin pointer at port 0.
    valid[1] = 1'b1;
    req[1] = mk(4'd5, 32'h102, 1'b1, 2'd1, 32'h1234);
    mem_gnt = 1'b1;
    #1;
    total++;
    if ({mem_be, mem_wdata, mem_addr, mem_we, ready} !== {4'hC, 32'h12340000, 32'h100, 1'b1, 2'b10})
      $display("FAIL half_store: got be=%h wdata=%h addr=%h we=%b ready=%b, want c 12340000 100 1 10",
               mem_be, mem_wdata, mem_addr, mem_we, ready);
    else pass_cnt++;
    tick();
    idle();
    mem_rvalid = 1'b1;
    #1;
    total++;
    if (res_valid !== 2'b00) $display("FAIL store_silent: got rv=%b, want 00", res_valid);
    else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ready [4];
    logic [1:0]  exp_port  [4];
    logic [3:0]  exp_id    [4];
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_port  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id    = '{4'd0, 4'd5, 4'd2, 4'd7};
    for (int k = 0; k < 4; k++) begin
      valid = 2'b11;
      req[0] = mk(4'(k), 32'h200, 1'b0, 2'd2, 32'h0);
      req[1] = mk(4'(4 + k), 32'h300, 1'b0, 2'd2, 32'h0);
      mem_gnt = 1'b1;
      #1;
      total++;
      if (ready !== exp_ready[k]) $display("FAIL rr_grant%0d: got ready=%b, want %b", k, ready, exp_ready[k]);
      else pass_cnt++;
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h1000 + k;
      #1;
      total++;
      if ({res_valid, res[k%2].id, res[k%2].rdata} !== {exp_port[k], exp_id[k], 32'h1000 + k})
        $display("FAIL rr_result%0d: got rv=%b id=%0d rdata=%h, want %b %0d %h",
                 k, res_valid, res[k%2].id, res[k%2].rdata, exp_port[k], exp_id[k], 32'h1000 + k);
      else pass_cnt++;
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    int acc = 0;
    int got = 0;
    for (int k = 0; k < 6; k++) begin
      valid[0] = 1'b1;
      req[0] = mk(4'd9, 32'h300, 1'b0, 2'd2, 32'h0);
      mem_gnt = 1'b1;
      #1;
      if (ready[0]) acc++;
      if (k == 5) begin
        total++;
        if (mem_req !== 1'b0) $display("FAIL full_no_req: got mem_req=%b, want 0", mem_req);
        else pass_cnt++;
      end
      tick();
    end
    total++;
    if (acc !== 4) $display("FAIL full_accepts: got %0d accepted, want 4", acc);
    else pass_cnt++;
    mem_rvalid = 1'b1; mem_rdata = 32'h1;
    #1;
    total++;
    if ({ready, res_valid} !== {2'b00, 2'b01})
      $display("FAIL full_pop_cycle: got ready=%b rv=%b, want 00 01", ready, res_valid);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    #1;
    total++;
    if (ready !== 2'b01) $display("FAIL full_fifth: got ready=%b, want 01", ready);
    else pass_cnt++;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      #1;
      if (res_valid === 2'b01 && res[0].id === 4'd9) got++;
      tick();
    end
    idle();
    total++;
    if (got !== 4) $display("FAIL full_drain: got %0d results, want 4", got);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    valid[0] = 1'b1;
    req[0] = mk(4'd2, 32'h102, 1'b0, 2'd2, 32'h0);
    #1;
    total++;
    if ({ready, resp[0].exc, resp[0].exccode, mem_req, res_valid} !== {2'b01, 1'b1, 6'd4, 1'b0, 2'b00})
      $display("FAIL misal_load: got ready=%b exc=%b code=%0d req=%b rv=%b, want 01 1 4 0 00",
               ready, resp[0].exc, resp[0].exccode, mem_req, res_valid);
    else pass_cnt++;
    tick();
    idle();
    valid[1] = 1'b1;
    req[1] = mk(4'd3, 32'h101, 1'b1, 2'd1, 32'h0);
    #1;
    total++;
    if ({ready, resp[1].exc, resp[1].exccode, mem_req} !== {2'b10, 1'b1, 6'd6, 1'b0})
      $display("FAIL misal_store: got ready=%b exc=%b code=%0d req=%b, want 10 1 6 0",
               ready, resp[1].exc, resp[1].exccode, mem_req);
    else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 3; k++) begin
      valid[0] = 1'b1;
      req[0] = mk(4'(k), 32'h400, 1'b0, 2'd2, 32'h0);
      mem_gnt = 1'b1;
      tick();
    end
    valid = 2'b11;
    req[1] = mk(4'd6, 32'h500, 1'b0, 2'd2, 32'h0);
    rst = 1'b1;
    #1;
    total++;
    if ({mem_req, ready, res_valid, mem_addr} !== 37'h0)
      $display("FAIL reset_mid: got req=%b ready=%b rv=%b addr=%h, want all 0", mem_req, ready, res_valid, mem_addr);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    req[0] = mk(4'd5, 32'h400, 1'b0, 2'd2, 32'h0);
    #1;
    total++;
    if (ready !== 2'b01) $display("FAIL reset_rr_ptr: got ready=%b, want 01", ready);
    else pass_cnt++;
    tick();
    idle();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    #1;
    total++;
    if ({res_valid, res[0].id, res[0].rdata} !== {2'b01, 4'd5, 32'h55})
      $display("FAIL reset_new_load: got rv=%b id=%0d rdata=%h, want 01 5 00000055", res_valid, res[0].id, res[0].rdata);
    else pass_cnt++;
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_load();
    test_subword();
    test_round_robin();
    test_full();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
